// File: rtl/glitch_pkg.sv
// rtl/glitch_pkg.sv - shared state encoding, default widths and width helper for the glitch sequencer
package glitch_pkg;

    localparam int DEF_DELAY_W = 32;
    localparam int DEF_WIDTH_W = 16;
    localparam int DEF_GAP_W   = 16;
    localparam int DEF_COUNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_DELAY = 3'd2,
        ST_PULSE = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // Width of the shared down-counter: wide enough for any of the three intervals.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/trig_sync.sv
// rtl/trig_sync.sv - two-flop synchronizer plus registered rising-edge detector for the target trigger
//
// Ports:
//   clk_i    sequencer clock
//   rst_ni   asynchronous active-low reset
//   trig_i   asynchronous trigger from the target
//   rise_o   one-cycle pulse, high after the third edge that sees trig_i high
module trig_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic trig_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic rise_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= trig_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            // Registered so the FSM consumes the edge at a fixed point after the trigger.
            rise_q  <= sync2_q & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/glitch_sequencer.sv
// rtl/glitch_sequencer.sv - lock-gated fault-injection pulse train sequencer
//
// Ports:
//   CLK      PLL output clock, sole clock
//   RESETN   asynchronous active-low reset
//   LOCKED   PLL lock; any active train is cut when it drops
//   ARM      latch DELAY/WIDTH/GAP/COUNT and wait for a trigger
//   ABORT    return to idle, highest priority
//   TRIGGER  asynchronous target trigger (rising edge starts the train)
//   DELAY/WIDTH/GAP/COUNT  train configuration, sampled only on accepted ARM
//   GLITCH   registered glitch pulse output
//   ARMED    waiting for trigger
//   BUSY     delay, pulse or gap in progress
//   DONE     one-cycle completion strobe
//   UNLOCK   sticky lock-loss flag, cleared by accepted ARM
module glitch_sequencer
    import glitch_pkg::*;
#(
    parameter int DELAY_W = DEF_DELAY_W,
    parameter int WIDTH_W = DEF_WIDTH_W,
    parameter int GAP_W   = DEF_GAP_W,
    parameter int COUNT_W = DEF_COUNT_W
) (
    input  logic               CLK,
    input  logic               RESETN,
    input  logic               LOCKED,
    input  logic               ARM,
    input  logic               ABORT,
    input  logic               TRIGGER,
    input  logic [DELAY_W-1:0] DELAY,
    input  logic [WIDTH_W-1:0] WIDTH,
    input  logic [GAP_W-1:0]   GAP,
    input  logic [COUNT_W-1:0] COUNT,
    output logic               GLITCH,
    output logic               ARMED,
    output logic               BUSY,
    output logic               DONE,
    output logic               UNLOCK
);

    localparam int CNT_W = max3(DELAY_W, WIDTH_W, GAP_W);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [COUNT_W-1:0] pulses_left_q;
    logic [DELAY_W-1:0] cfg_delay_q;
    logic [WIDTH_W-1:0] cfg_width_m1_q;
    logic [GAP_W-1:0]   cfg_gap_m1_q;
    logic [COUNT_W-1:0] cfg_count_q;
    logic               glitch_q;
    logic               armed_q;
    logic               busy_q;
    logic               done_q;
    logic               unlock_q;
    logic               trig_rise;

    // Zero-valued width/gap/count behave as one; intervals are stored minus one
    // because the loading edge itself is the first cycle of the interval.
    logic [WIDTH_W-1:0] width_m1;
    logic [GAP_W-1:0]   gap_m1;
    logic [COUNT_W-1:0] count_n;

    assign width_m1 = (WIDTH == '0) ? '0 : WIDTH - WIDTH_W'(1);
    assign gap_m1   = (GAP == '0)   ? '0 : GAP - GAP_W'(1);
    assign count_n  = (COUNT == '0) ? COUNT_W'(1) : COUNT;

    trig_sync u_trig_sync (
        .clk_i  (CLK),
        .rst_ni (RESETN),
        .trig_i (TRIGGER),
        .rise_o (trig_rise)
    );

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            pulses_left_q  <= '0;
            cfg_delay_q    <= '0;
            cfg_width_m1_q <= '0;
            cfg_gap_m1_q   <= '0;
            cfg_count_q    <= '0;
            glitch_q       <= 1'b0;
            armed_q        <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            unlock_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ABORT) begin
                state_q  <= ST_IDLE;
                glitch_q <= 1'b0;
                armed_q  <= 1'b0;
                busy_q   <= 1'b0;
            end else if ((state_q != ST_IDLE) && !LOCKED) begin
                state_q  <= ST_IDLE;
                glitch_q <= 1'b0;
                armed_q  <= 1'b0;
                busy_q   <= 1'b0;
                unlock_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (ARM && LOCKED) begin
                            cfg_delay_q    <= DELAY;
                            cfg_width_m1_q <= width_m1;
                            cfg_gap_m1_q   <= gap_m1;
                            cfg_count_q    <= count_n;
                            unlock_q       <= 1'b0;
                            armed_q        <= 1'b1;
                            state_q        <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (trig_rise) begin
                            cnt_q         <= CNT_W'(cfg_delay_q);
                            pulses_left_q <= cfg_count_q;
                            armed_q       <= 1'b0;
                            busy_q        <= 1'b1;
                            state_q       <= ST_DELAY;
                        end
                    end
                    ST_DELAY: begin
                        if (cnt_q == '0) begin
                            cnt_q    <= CNT_W'(cfg_width_m1_q);
                            glitch_q <= 1'b1;
                            state_q  <= ST_PULSE;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    ST_PULSE: begin
                        if (cnt_q == '0) begin
                            glitch_q <= 1'b0;
                            if (pulses_left_q == COUNT_W'(1)) begin
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                state_q <= ST_IDLE;
                            end else begin
                                cnt_q   <= CNT_W'(cfg_gap_m1_q);
                                state_q <= ST_GAP;
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    ST_GAP: begin
                        if (cnt_q == '0) begin
                            cnt_q         <= CNT_W'(cfg_width_m1_q);
                            pulses_left_q <= pulses_left_q - COUNT_W'(1);
                            glitch_q      <= 1'b1;
                            state_q       <= ST_PULSE;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    default: begin
                        glitch_q <= 1'b0;
                        armed_q  <= 1'b0;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign GLITCH = glitch_q;
    assign ARMED  = armed_q;
    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign UNLOCK = unlock_q;

endmodule
